// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester byte-stream bundle between message sources and the UART scheduler
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - message-locking byte scheduler feeding one UART transmitter
// Define UART_TX_SCHED_RR_EN for round-robin arbitration; default is fixed priority (index 0 wins).
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int TMO  = 15
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_sched_if.slave   rq,
  input  logic             cts,
  input  logic             tx_ing,
  input  logic             err_clr,
  output logic             txen,
  output logic [7:0]       tx_byte,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             tmo_err,
  output logic [15:0]      tx_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic            txen_q, txen_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            tmo_err_q, tmo_err_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] sel;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cidx;
  logic            found;
  logic            accept;

`ifdef UART_TX_SCHED_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
  int              cand;
`endif

  // A locked message restricts eligibility to its owner, even when the owner is idle.
  always_comb begin
    elig    = (grant_q != '0) ? (rq.req_valid & grant_q) : rq.req_valid;
    found   = 1'b0;
    sel_idx = '0;
    cidx    = '0;
`ifdef UART_TX_SCHED_RR_EN
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IW'(cand);
      if (!found && elig[cidx]) begin
        found   = 1'b1;
        sel_idx = cidx;
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      cidx = IW'(i);
      if (elig[cidx]) begin
        found   = 1'b1;
        sel_idx = cidx;
      end
    end
`endif
  end

  assign sel          = ONE << sel_idx;
  assign accept       = (state_q == IDLE) && !cts && found && rstn;
  assign rq.req_ready = accept ? sel : '0;

  always_comb begin
    state_d   = state_q;
    txen_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    grant_d   = grant_q;
    tmo_err_d = err_clr ? 1'b0 : tmo_err_q;
    tx_cnt_d  = tx_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
`ifdef UART_TX_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          txen_d    = 1'b1;
          tx_byte_d = rq.req_data[sel_idx];
          grant_d   = rq.req_last[sel_idx] ? '0 : sel;
`ifdef UART_TX_SCHED_RR_EN
          if (rq.req_last[sel_idx])
            ptr_d = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;
`endif
        end
      end
      ISSUE: begin
        state_d   = WAIT_BUSY;
        tx_cnt_d  = tx_cnt_q + 16'd1;
        tmo_cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (tx_ing) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == 8'(TMO - 1)) begin
          // Timeout set overrides a simultaneous clear.
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_ing) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      txen_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      grant_q   <= '0;
      tmo_err_q <= 1'b0;
      tx_cnt_q  <= 16'h0000;
      tmo_cnt_q <= 8'h00;
`ifdef UART_TX_SCHED_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      txen_q    <= txen_d;
      tx_byte_q <= tx_byte_d;
      grant_q   <= grant_d;
      tmo_err_q <= tmo_err_d;
      tx_cnt_q  <= tx_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
`ifdef UART_TX_SCHED_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign txen    = txen_q;
  assign tx_byte = tx_byte_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign tmo_err = tmo_err_q;
  assign tx_cnt  = tx_cnt_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a simple UART busy model
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int TMO  = 15;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cts = 1'b0;
  logic            tx_ing = 1'b0;
  logic            err_clr = 1'b0;
  logic            txen;
  logic [7:0]      tx_byte;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            tmo_err;
  logic [15:0]     tx_cnt;

  uart_tx_sched_if #(.NREQ(NREQ)) rif ();

  uart_tx_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .rq(rif), .cts(cts), .tx_ing(tx_ing), .err_clr(err_clr),
    .txen(txen), .tx_byte(tx_byte), .grant(grant), .busy(busy), .tmo_err(tmo_err), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              req;
    logic [7:0]      data;
    logic [NREQ-1:0] grant;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] sq[NREQ][$];
  int         errs = 0;
  int         checks = 0;
  int         exp_cnt = 0;
  int         cyc = 0;
  int         acc_cyc = -10;
  int         acc_idx = -1;
  bit         drv_on = 1'b0;
  bit         uart_on = 1'b1;
  int         dly = 0;
  int         hold = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input bit last);
    exp_t e;
    sq[r].push_back({last, d});
    e.req   = r;
    e.data  = d;
    e.grant = last ? '0 : (NREQ'(1) << r);
    exp_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !busy && !tx_ing && dly == 0 && hold == 0;
      for (int i = 0; i < NREQ; i++) if (sq[i].size() != 0) done = 1'b0;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tx_ing(input int budget);
    int n;
    n = 0;
    while (!tx_ing && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ing) chk("tx_ing_timeout", 32'd0, 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model: busy rises 3 cycles after txen and stays up for 3 cycles.
  initial forever begin
    @(negedge clk);
    if (hold > 0) begin
      hold--;
      if (hold == 0) tx_ing = 1'b0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        tx_ing = 1'b1;
        hold   = 3;
      end
    end
    if (txen && uart_on) dly = 3;
  end

  // Requester driver: inputs change on negedge, acceptance sampled just after.
  initial begin
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    forever begin
      @(negedge clk);
      if (drv_on) begin
        for (int i = 0; i < NREQ; i++) begin
          if (sq[i].size() != 0) begin
            rif.req_valid[i] = 1'b1;
            rif.req_data[i]  = sq[i][0][7:0];
            rif.req_last[i]  = sq[i][0][8];
          end else begin
            rif.req_valid[i] = 1'b0;
            rif.req_data[i]  = 8'h00;
            rif.req_last[i]  = 1'b0;
          end
        end
      end
      #1;
      if (drv_on) begin
        for (int i = 0; i < NREQ; i++) begin
          if (rif.req_ready[i] && sq[i].size() != 0) begin
            void'(sq[i].pop_front());
            acc_cyc = cyc;
            acc_idx = i;
          end
        end
      end
    end
  end

  // Output monitor: every txen pulse must match the next scoreboard entry.
  initial forever begin
    @(negedge clk);
    if (txen) begin
      if (exp_q.size() == 0) begin
        chk("txen_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_byte), 32'(e.data));
        chk("acc_req", 32'(acc_idx), 32'(e.req));
        chk("acc_to_txen", 32'(cyc - acc_cyc), 32'd1);
        chk("grant", 32'(grant), 32'(e.grant));
      end
    end
  end

  initial begin
    int k;
    int bad;

    // Reset values, with every requester asserting valid.
    rif.req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_txen", 32'(txen), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo_err", 32'(tmo_err), 32'd0);
    chk("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    rif.req_valid = '0;
    @(negedge clk);
    rstn   = 1'b1;
    drv_on = 1'b1;

    // Arbitration with all four requesting single-byte messages.
`ifdef UART_TX_SCHED_RR_EN
    send(0, 8'hA0, 1'b1);
    send(1, 8'hB1, 1'b1);
    send(2, 8'hC2, 1'b1);
    send(3, 8'hD3, 1'b1);
    send(0, 8'hA4, 1'b1);
`else
    send(0, 8'hA0, 1'b1);
    send(0, 8'hA1, 1'b1);
    send(0, 8'hA2, 1'b1);
    send(1, 8'hB1, 1'b1);
    send(2, 8'hC2, 1'b1);
    send(3, 8'hD3, 1'b1);
`endif
    wait_idle(600);
    chk("arb_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));

    // Single byte from requester 2.
    send(2, 8'h41, 1'b1);
    wait_idle(200);
    chk("single_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_grant", 32'(grant), 32'd0);

    // Locked two-byte message from requester 1 while requester 0 stays valid.
    send(1, 8'h10, 1'b0);
    send(1, 8'h11, 1'b1);
    k = 0;
    while (sq[1].size() == 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    send(0, 8'h20, 1'b1);
    send(0, 8'h21, 1'b1);
    send(0, 8'h22, 1'b1);
    wait_idle(600);
    chk("lock_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));
    chk("lock_grant_end", 32'(grant), 32'd0);

    // cts raised during WAIT_DONE blocks the next byte until released.
    send(3, 8'h55, 1'b1);
    wait_tx_ing(50);
    @(negedge clk);
    cts = 1'b1;
    send(3, 8'h56, 1'b1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (rif.req_ready != '0) bad++;
    end
    chk("cts_no_ready", 32'(bad), 32'd0);
    chk("cts_cur_done", 32'(busy), 32'd0);
    chk("cts_pending", 32'(exp_q.size()), 32'd1);
    @(negedge clk);
    cts = 1'b0;
    #1;
    chk("cts_resume", 32'(rif.req_ready), 32'b1000);
    wait_idle(200);
    chk("cts_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));

    // Timeout: the UART never reports busy.
    uart_on = 1'b0;
    send(0, 8'h77, 1'b1);
    k = 0;
    while (!txen && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_txen_seen", 32'(txen), 32'd1);
    k = 0;
    while (!tmo_err && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", 32'(k), 32'(TMO + 1));
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));
    repeat (3) @(negedge clk);
    chk("tmo_sticky", 32'(tmo_err), 32'd1);
    chk("tmo_tx_cnt_hold", 32'(tx_cnt), 32'(exp_cnt));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("tmo_cleared", 32'(tmo_err), 32'd0);
    uart_on = 1'b1;
    wait_idle(100);

    // Reset mid-message while requester 1 holds the lock.
    send(1, 8'h30, 1'b0);
    wait_tx_ing(50);
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'b0010);
    chk("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_txen", 32'(txen), 32'd0);
    chk("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_cnt", 32'(tx_cnt), 32'd0);
    chk("mid_rst_ready", 32'(rif.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_idle(100);

    send(3, 8'h99, 1'b1);
    wait_idle(200);
    chk("post_rst_tx_cnt", 32'(tx_cnt), 32'(exp_cnt));
    chk("post_rst_grant", 32'(grant), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
